// File: rtl/mem_arb.sv
// Round-robin arbiter sharing a single-ported memory among NREQ requesters.
// Tenure is held while req stays high; unlocked owners are preempted after MAX_HOLD cycles.
module mem_arb #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   rq_rd_addr,
    input  logic [NREQ-1:0]          rq_wr_en,
    input  logic [NREQ*ADDR_W-1:0]   rq_wr_addr,
    input  logic [NREQ*DATA_W-1:0]   rq_wr_data,
    output logic [NREQ-1:0]          gnt,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     mem_wr_en,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    output logic                     viol
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic            owner_req, owner_lock, others, new_gnt;

    // Rotate candidates so 'start' is bit 0, isolate the lowest set bit, rotate back.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] cand,
                                                 input logic [PW-1:0]   start);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        logic [NREQ-1:0]   oh;
        dbl = {cand, cand} >> start;
        rot = dbl[NREQ-1:0];
        oh  = rot & (~rot + NREQ'(1));
        dbl = {oh, oh} << start;
        return dbl[2*NREQ-1:NREQ];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= '0;
            viol  <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            viol  <= |(rq_wr_en & ~gnt);
        end
    end

    always_comb begin
        owner_req  = |(req & gnt);
        owner_lock = |(lock & gnt);
        others     = |(req & ~gnt);
        state_n    = state;
        gnt_n      = gnt;
        cnt_n      = cnt;
        ptr_n      = ptr;
        new_gnt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_n   = rr_pick(req, ptr);
                    cnt_n   = CW'(1);
                    state_n = OWNED;
                    new_gnt = 1'b1;
                end
            end
            OWNED: begin
                // ptr already sits at owner+1, so excluding the owner makes it lowest priority
                if (!owner_req || (cnt == CW'(MAX_HOLD) && !owner_lock && others)) begin
                    gnt_n = rr_pick(req & ~gnt, ptr);
                    if (gnt_n == '0) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = CW'(1);
                        new_gnt = 1'b1;
                    end
                end else if (cnt != CW'(MAX_HOLD)) begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase

        if (new_gnt) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt_n[i]) ptr_n = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_comb begin
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_rd_addr = rq_rd_addr[i*ADDR_W +: ADDR_W];
                mem_wr_en   = rq_wr_en[i];
                mem_wr_addr = rq_wr_addr[i*ADDR_W +: ADDR_W];
                mem_wr_data = rq_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed scenarios plus random traffic against a
// behavioural arbitration and memory model.
module tb_mem_arb;

    localparam int N    = 3;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int MAXH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, rq_wr_en, gnt;
    logic [N*AW-1:0] rq_rd_addr, rq_wr_addr;
    logic [N*DW-1:0] rq_wr_data;
    logic [DW-1:0]   rd_data, mem_rd_data, mem_wr_data;
    logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
    logic            mem_wr_en, viol;

    logic [DW-1:0] mem   [1<<AW] = '{default: '0};
    logic [DW-1:0] m_mem [1<<AW] = '{default: '0};

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          viol;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] rd_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   m_owner, m_cnt, m_ptr;
    logic m_viol;

    mem_arb #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .rq_rd_addr(rq_rd_addr), .rq_wr_en(rq_wr_en), .rq_wr_addr(rq_wr_addr),
        .rq_wr_data(rq_wr_data), .gnt(gnt), .rd_data(rd_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .viol(viol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    assign mem_rd_data = mem[mem_rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_viol  = 1'b0;
    endtask

    // Called right after a falling edge: drive one cycle, record expectations, advance the model.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] we,
                         input logic [N*AW-1:0] wa, input logic [N*DW-1:0] wd,
                         input logic [N*AW-1:0] ra);
        exp_t e;
        int   nxt;
        req = r; lock = l; rq_wr_en = we; rq_wr_addr = wa; rq_wr_data = wd; rq_rd_addr = ra;
        #1;
        e = '0;
        e.viol = m_viol;
        if (m_owner >= 0) begin
            e.gnt     = N'(1) << m_owner;
            e.wr_en   = we[m_owner];
            e.wr_addr = wa[m_owner*AW +: AW];
            e.wr_data = wd[m_owner*DW +: DW];
            e.rd_addr = ra[m_owner*AW +: AW];
        end
        e.rd_data = m_mem[e.rd_addr];
        sb.push_back(e);

        if (e.wr_en) m_mem[e.wr_addr] = e.wr_data;
        m_viol = |(we & ~e.gnt);
        nxt = -1;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (nxt < 0 && r[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
            if (nxt >= 0) begin
                m_owner = nxt; m_cnt = 1; m_ptr = (nxt + 1) % N;
            end
        end else if (!r[m_owner] || (m_cnt >= MAXH && !l[m_owner] && |(r & ~e.gnt))) begin
            for (int k = 1; k < N; k++)
                if (nxt < 0 && r[(m_owner + k) % N]) nxt = (m_owner + k) % N;
            if (nxt >= 0) begin
                m_owner = nxt; m_cnt = 1; m_ptr = (nxt + 1) % N;
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end else if (m_cnt < MAXH) begin
            m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, '0, '0, '0, '0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gnt",     32'(gnt),         32'(e.gnt));
                check("viol",    32'(viol),        32'(e.viol));
                check("wr_en",   32'(mem_wr_en),   32'(e.wr_en));
                check("wr_addr", 32'(mem_wr_addr), 32'(e.wr_addr));
                check("wr_data", 32'(mem_wr_data), 32'(e.wr_data));
                check("rd_addr", 32'(mem_rd_addr), 32'(e.rd_addr));
                check("rd_data", 32'(rd_data),     32'(e.rd_data));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [N-1:0]    rs, ls, we;
        logic [N*AW-1:0] wa, ra;
        logic [N*DW-1:0] wd;
        logic [DW-1:0]   old;

        rst = 1'b0;
        req = '1; lock = '0; rq_wr_en = '1;
        rq_wr_addr = '0; rq_wr_data = '1; rq_rd_addr = '0;
        #3;
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_viol",  32'(viol),      32'h0);
        check("rst_wr_en", 32'(mem_wr_en), 32'h0);
        @(posedge clk); #1;
        check("rst_hold_gnt",   32'(gnt),       32'h0);
        check("rst_hold_wr_en", 32'(mem_wr_en), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // single requester with a write to address 5
        wa = '0; wd = '0;
        wa[1*AW +: AW] = AW'(5);
        wd[1*DW +: DW] = 8'hA7;
        idle(2);
        cycle(3'b010, '0, '0, '0, '0, '0);
        cycle(3'b010, '0, 3'b010, wa, wd, wa);
        cycle(3'b010, '0, '0, '0, '0, wa);
        idle(2);
        check("single_write_mem5", 32'(mem[5]), 32'hA7);

        // full contention: three 16-cycle tenures back to back and more
        repeat (60) cycle(3'b111, '0, '0, '0, '0, '0);
        idle(2);

        // locked owner keeps the grant against a waiting requester
        cycle(3'b010, 3'b010, '0, '0, '0, '0);
        repeat (100) cycle(3'b011, 3'b010, '0, '0, '0, '0);
        repeat (3) cycle(3'b001, '0, '0, '0, '0, '0);
        idle(2);

        // release handoff from owner 2 wraps to requester 0
        cycle(3'b100, '0, '0, '0, '0, '0);
        repeat (3) cycle(3'b111, '0, '0, '0, '0, '0);
        repeat (2) cycle(3'b011, '0, '0, '0, '0, '0);
        idle(2);

        // ungranted write is dropped
        old = mem[3];
        wa = '0; wd = '0;
        wa[0 +: AW] = AW'(3);
        wd[0 +: DW] = ~old;
        cycle(3'b100, '0, '0, '0, '0, '0);
        cycle(3'b100, '0, 3'b001, wa, wd, '0);
        idle(3);
        check("viol_mem3_kept", 32'(mem[3]), 32'(old));

        // random traffic
        rs = '0; ls = '0;
        repeat (2500) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0)  rs[i] = ~rs[i];
                if ($urandom_range(15) == 0) ls[i] = ~ls[i];
                we[i] = ($urandom_range(2) == 0);
                wa[i*AW +: AW] = AW'($urandom);
                ra[i*AW +: AW] = AW'($urandom);
                wd[i*DW +: DW] = DW'($urandom);
            end
            cycle(rs, ls, we, wa, wd, ra);
        end
        idle(3);

        // reset in the middle of requester 1's write cycle
        cycle(3'b010, '0, '0, '0, '0, '0);
        old = mem[7];
        wa = '0; wd = '0;
        wa[1*AW +: AW] = AW'(7);
        wd[1*DW +: DW] = ~old;
        req = 3'b010; lock = '0; rq_wr_en = 3'b010; rq_wr_addr = wa; rq_wr_data = wd; rq_rd_addr = '0;
        #1;
        check("pre_rst_gnt", 32'(gnt), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(gnt),       32'h0);
        check("mid_rst_wr_en", 32'(mem_wr_en), 32'h0);
        model_reset();
        @(negedge clk);
        check("mid_rst_mem7_kept", 32'(mem[7]), 32'(old));
        rst = 1'b1;
        cycle(3'b110, '0, '0, '0, '0, '0);
        cycle(3'b110, '0, '0, '0, '0, '0);
        idle(3);

        #3;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Arbiter that shares the single-ported sort memory between NREQ requesters: the host loader, the sort controller and the result checker. The memory has one combinational read port and one clocked write port. The arbiter grants the memory to one requester at a time using round-robin, with tenure held while the request stays high. Unlocked owners are preempted after MAX_HOLD cycles. It sits between the requesters and the memory instance in the top level.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_W, 5, memory address width
DATA_W, 8, memory data width
MAX_HOLD, 16, max consecutive granted cycles for an unlocked owner when others wait (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req  input  NREQ  per-requester access request
lock  input  NREQ  per-requester no-preempt hint (sorter holds high for a whole sort)
rq_rd_addr  input  NREQ*ADDR_W  flattened per-requester read addresses, slice i = requester i
rq_wr_en  input  NREQ  per-requester write enable
rq_wr_addr  input  NREQ*ADDR_W  flattened per-requester write addresses
rq_wr_data  input  NREQ*DATA_W  flattened per-requester write data
gnt  output  NREQ  one-hot registered grant
rd_data  output  DATA_W  mem_rd_data broadcast to all requesters
mem_rd_addr  output  ADDR_W  to memory
mem_rd_data  input  DATA_W  from memory (combinational)
mem_wr_en  output  1  to memory
mem_wr_addr  output  ADDR_W  to memory
mem_wr_data  output  DATA_W  to memory
viol  output  1  pulse: an ungranted requester drove wr_en

Behaviour:
- Reset (rst low, async): gnt=0, viol=0, hold counter=0, round-robin pointer=0 (requester 0 highest priority). Outputs are 0 immediately, with mem_wr_en=0 in the same cycle. No write may occur while rst is low.
- States: IDLE (gnt==0) and OWNED (exactly one gnt bit set). gnt is always one-hot or zero.
- IDLE -> OWNED: at the clock edge where any req is high, grant the first requesting index at or after the pointer (cyclic). Latency is req high in cycle N, gnt high from edge N+1. The hold counter loads 1.
- OWNED, owner req high, and either no other req or owner lock high, or counter < MAX_HOLD: keep grant. The counter increments and saturates at MAX_HOLD.
- OWNED, owner req low at an edge: release. In the same edge, grant the next requester after the owner if any is requesting (zero-bubble handoff); otherwise go to IDLE.
- Preemption: counter == MAX_HOLD, owner lock low, another req high. At the next edge, move the grant to the next requester after the owner. The counter reloads to 1.
- Pointer updates to owner+1 (mod NREQ) on every new grant.
- Muxing is combinational from registered gnt:
  - In OWNED, mem_rd_addr, mem_wr_en, mem_wr_addr and mem_wr_data come from the owner's slices.
  - In IDLE, mem_wr_en=0 and addresses/data are 0.
- The owner's writes in its last granted cycle (the cycle before gnt drops) are performed.
- rd_data = mem_rd_data at all times. It is only meaningful to the owner in the same cycle as its rd_addr.
- viol: registered, 1-cycle pulse on the edge after any cycle in which rq_wr_en[i]=1 and gnt[i]=0. That write is dropped.
- lock on a non-owner has no effect. lock alone without req never obtains a grant.
- Simultaneous release and new requests: the round-robin order decides, and the released owner is lowest priority.
- Reset mid-operation: an in-flight tenure is abandoned and no partial write is issued. After rst rises, arbitration restarts from the pointer at 0.

Test Plan:
- Single requester: req[1] high at cycle 3 -> gnt=3'b010 from cycle 4. A write (addr 5, data 8'hA7) is issued while granted -> memory[5]=A7. When req[1] drops, gnt=0 at the next edge.
- Contention from reset: req=3'b111 held, lock=0, MAX_HOLD=16 -> grants cycle 0->1->2->0, each tenure exactly 16 cycles, handoff with no idle cycle.
- Lock: requester 1 holds req and lock for 100 cycles while req[0] is high -> gnt stays 3'b010 for 100 cycles. Requester 0 is granted the edge after req[1] drops.
- Release handoff: owner 2 drops req while req[0] and req[1] are high -> next gnt=3'b001 (cyclic after 2), same edge.
- Violation: requester 0 drives wr_en (addr 3, data 8'h55) while gnt=3'b100 -> memory[3] unchanged, viol pulses for exactly one cycle.
- Reset mid-tenure: rst low during requester 1's write cycle -> gnt=0 and mem_wr_en=0 immediately, memory unchanged. After release with req=3'b110, gnt=3'b010 first.
